// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte over valid/ready and serializes it as an
// 8N1 frame (8E1 when PARITY_EN is set), LSB first, with a registered line output.
module uart_tx #(
  parameter int DIV       = 868,
  parameter int PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Bit-period counter wraps on each tick, which is also every state change
    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (tx_valid_i && ready_q) begin
          data_d  = tx_data_i;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = data_q[0];
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = ^data_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset forces the line high so an aborted frame never glitches low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (DIV=4 8N1, DIV=4 8E1, DIV=2 8N1)
// checked against hand-computed frame bit patterns sampled on the falling edge.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  int         sel = 0;

  logic       valid0, valid1, valid2;
  logic       ready0, ready1, ready2;
  logic       txl0, txl1, txl2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       tx_mon, ready_mon, busy_mon, done_mon;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign valid0 = tx_valid && (sel == 0);
  assign valid1 = tx_valid && (sel == 1);
  assign valid2 = tx_valid && (sel == 2);

  uart_tx #(.DIV(4), .PARITY_EN(0)) u_div4 (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(valid0),
    .tx_ready_o(ready0), .tx_o(txl0), .busy_o(busy0), .done_o(done0));

  uart_tx #(.DIV(4), .PARITY_EN(1)) u_par (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(valid1),
    .tx_ready_o(ready1), .tx_o(txl1), .busy_o(busy1), .done_o(done1));

  uart_tx #(.DIV(2), .PARITY_EN(0)) u_div2 (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(valid2),
    .tx_ready_o(ready2), .tx_o(txl2), .busy_o(busy2), .done_o(done2));

  always_comb begin
    tx_mon    = txl0;
    ready_mon = ready0;
    busy_mon  = busy0;
    done_mon  = done0;
    case (sel)
      1: begin tx_mon = txl1; ready_mon = ready1; busy_mon = busy1; done_mon = done1; end
      2: begin tx_mon = txl2; ready_mon = ready2; busy_mon = busy2; done_mon = done2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge with the selected instance idle. Accepts at the
  // next rising edge (E0), then checks every clock of the frame and the end.
  task automatic run_frame(input string tag, input logic [7:0] data,
                           input logic [7:0] late_data, input logic [10:0] exp_frame,
                           input int nbits, input int div, input logic hold_valid);
    check({tag, " ready_before"}, ready_mon, 1'b1);
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) tx_valid = 1'b0;
    for (int t = 0; t < nbits * div; t++) begin
      if (t == 1) tx_data = late_data;
      check($sformatf("%s tx t=%0d", tag, t), tx_mon, exp_frame[t / div]);
      check($sformatf("%s busy t=%0d", tag, t), busy_mon, 1'b1);
      check($sformatf("%s ready t=%0d", tag, t), ready_mon, 1'b0);
      check($sformatf("%s done t=%0d", tag, t), done_mon, 1'b0);
      @(negedge clk);
    end
    check({tag, " done_end"}, done_mon, 1'b1);
    check({tag, " ready_end"}, ready_mon, 1'b1);
    check({tag, " busy_end"}, busy_mon, 1'b0);
    check({tag, " tx_end"}, tx_mon, 1'b1);
  endtask

  initial begin
    // Reset held low for two cycles
    #2 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst tx c=%0d", c), txl0, 1'b1);
      check($sformatf("rst busy c=%0d", c), busy0, 1'b0);
      check($sformatf("rst done c=%0d", c), done0, 1'b0);
      check($sformatf("rst ready c=%0d", c), ready0, 1'b0);
    end
    rst = 1'b1;
    #1 check("ready_still_low", ready0, 1'b0);
    @(negedge clk);
    check("ready_after_release", ready0, 1'b1);
    check("tx_idle_after_release", txl0, 1'b1);

    // 0xA5 at DIV=4: 0,1,0,1,0,0,1,0,1,1 (k0 in bit 0)
    sel = 0;
    run_frame("a5", 8'hA5, 8'hA5, 11'b00_1101001010, 10, 4, 1'b0);
    @(negedge clk);
    check("a5 done_one_cycle", done_mon, 1'b0);
    check("a5 idle_tx", tx_mon, 1'b1);

    // Back-to-back 0x00 then 0xFF with valid held; second frame starts at E0+41
    run_frame("b2b0", 8'h00, 8'h00, 11'b00_1000000000, 10, 4, 1'b1);
    run_frame("b2b1", 8'hFF, 8'hFF, 11'b00_1111111110, 10, 4, 1'b0);
    @(negedge clk);
    check("b2b done_low", done_mon, 1'b0);
    check("b2b busy_low", busy_mon, 1'b0);

    // 0x07 with even parity: three ones gives parity 1, 44-clock frame
    sel = 1;
    run_frame("par07", 8'h07, 8'h07, 11'b11000001110, 11, 4, 1'b0);
    @(negedge clk);
    check("par07 done_one_cycle", done_mon, 1'b0);

    // 0x3C accepted, input switched to 0xC3 at E0+1
    sel = 0;
    run_frame("late3c", 8'h3C, 8'hC3, 11'b00_1001111000, 10, 4, 1'b0);
    @(negedge clk);

    // Reset during D3 of 0x55 (D3 occupies E0+16..E0+19)
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mid d3_value", tx_mon, 1'b0);
    check("mid busy_before", busy_mon, 1'b1);
    rst = 1'b0;
    #1;
    check("mid tx_forced", tx_mon, 1'b1);
    check("mid busy_cleared", busy_mon, 1'b0);
    check("mid ready_cleared", ready_mon, 1'b0);
    check("mid no_done", done_mon, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("mid hold done c=%0d", c), done_mon, 1'b0);
      check($sformatf("mid hold tx c=%0d", c), tx_mon, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid ready_after", ready_mon, 1'b1);
    check("mid done_after", done_mon, 1'b0);
    run_frame("fresh55", 8'h55, 8'h55, 11'b00_1010101010, 10, 2 * 2, 1'b0);
    @(negedge clk);

    // DIV=2 boundary: every bit exactly two clocks
    sel = 2;
    run_frame("div2a5", 8'hA5, 8'hA5, 11'b00_1101001010, 10, 2, 1'b0);
    @(negedge clk);
    check("div2 done_one_cycle", done_mon, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
